// File: rtl/tqvp_wdt_escalator.sv
// Watchdog escalation stage: grace period after a watchdog timeout, then a stretched reset request.
// Optional build macro WDT_ESC_IRQ_EN drives user_interrupt high while in GRACE.
//
// state    | meaning
// IDLE     | waiting for a watchdog rising edge while armed
// GRACE    | software may still acknowledge; grace_cnt runs down
// PULSE    | sys_reset_req asserted for max(PULSE,1) cycles, cannot be aborted
// HOLDOFF  | minimum dwell after a pulse, then wait for the timeout to clear
module tqvp_wdt_escalator #(
    parameter int GRACE_W = 16,
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wdt_timeout,
    input  logic [7:0]  ui_in,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic [7:0]  uo_out,
    output logic        sys_reset_req,
    output logic        user_interrupt
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF < 1) ? 1 : HOLDOFF);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRACE   = 2'd1,
        S_PULSE   = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t              state;
    logic                arm;
    logic [GRACE_W-1:0]  grace_reg;
    logic [7:0]          pulse_reg;
    logic                wdt_prev;
    logic [GRACE_W-1:0]  grace_cnt;
    logic [7:0]          pulse_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                in_grace;
    logic                sticky_fired;
    logic [7:0]          fire_count;
    logic [31:0]         rd_data;

    logic wr_en, rd_en, wr_ctrl, ack_ok, disarm, clr, trigger;
    logic [7:0] pulse_load, fire_next;

    assign wr_en      = (data_write_n != 2'b11);
    assign rd_en      = (data_read_n != 2'b11);
    assign wr_ctrl    = wr_en && (address == 6'd0);
    assign ack_ok     = wr_en && (address == 6'd4) && (data_in[7:0] == 8'h5A);
    assign disarm     = wr_ctrl && !data_in[0];
    assign clr        = wr_ctrl && data_in[1];
    assign trigger    = wdt_timeout && !wdt_prev;
    assign pulse_load = (pulse_reg == 8'd0) ? 8'd1 : pulse_reg;
    assign fire_next  = (fire_count == 8'hFF) ? fire_count : fire_count + 8'd1;

    logic unused_inputs;
    assign unused_inputs = ^{ui_in, data_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm       <= 1'b0;
            grace_reg <= '0;
            pulse_reg <= 8'd0;
            wdt_prev  <= 1'b0;
        end else begin
            wdt_prev <= wdt_timeout;
            if (wr_ctrl) arm <= data_in[0];
            if (wr_en && address == 6'd1) grace_reg <= data_in[GRACE_W-1:0];
            if (wr_en && address == 6'd2) pulse_reg <= data_in[7:0];
        end
    end

    // Entering PULSE updates sticky/count after the clear so the increment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grace_cnt     <= '0;
            pulse_cnt     <= 8'd0;
            hold_cnt      <= '0;
            sys_reset_req <= 1'b0;
            in_grace      <= 1'b0;
            sticky_fired  <= 1'b0;
            fire_count    <= 8'd0;
        end else begin
            if (clr) begin
                sticky_fired <= 1'b0;
                fire_count   <= 8'd0;
            end
            case (state)
                S_IDLE: begin
                    if (trigger && arm) begin
                        if (grace_reg != '0) begin
                            state     <= S_GRACE;
                            grace_cnt <= grace_reg;
                            in_grace  <= 1'b1;
                        end else begin
                            state         <= S_PULSE;
                            pulse_cnt     <= pulse_load;
                            sys_reset_req <= 1'b1;
                            sticky_fired  <= 1'b1;
                            fire_count    <= fire_next;
                        end
                    end
                end
                S_GRACE: begin
                    if (ack_ok || disarm) begin
                        state     <= S_IDLE;
                        grace_cnt <= '0;
                        in_grace  <= 1'b0;
                    end else if (grace_cnt == GRACE_W'(1)) begin
                        state         <= S_PULSE;
                        grace_cnt     <= '0;
                        in_grace      <= 1'b0;
                        pulse_cnt     <= pulse_load;
                        sys_reset_req <= 1'b1;
                        sticky_fired  <= 1'b1;
                        fire_count    <= fire_next;
                    end else begin
                        grace_cnt <= grace_cnt - GRACE_W'(1);
                    end
                end
                S_PULSE: begin
                    if (pulse_cnt == 8'd1) begin
                        state         <= S_HOLDOFF;
                        pulse_cnt     <= 8'd0;
                        sys_reset_req <= 1'b0;
                        hold_cnt      <= HOLD_LOAD;
                    end else begin
                        pulse_cnt <= pulse_cnt - 8'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt > HOLD_W'(1)) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else if (!wdt_timeout) begin
                        state    <= S_IDLE;
                        hold_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (address)
            6'd0: rd_data = {31'd0, arm};
            6'd1: rd_data = 32'(grace_reg);
            6'd2: rd_data = {24'd0, pulse_reg};
            6'd3: rd_data = {16'd0, fire_count, 4'd0, wdt_timeout, sticky_fired, state};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_ready <= 1'b0;
            data_out   <= 32'd0;
        end else begin
            data_ready <= rd_en;
            data_out   <= rd_en ? rd_data : 32'd0;
        end
    end

    assign uo_out = {6'd0, in_grace, sys_reset_req};

`ifdef WDT_ESC_IRQ_EN
    assign user_interrupt = in_grace;
`else
    assign user_interrupt = 1'b0;
`endif

endmodule
